// File: rtl/proc_dispatch_unit_pkg.sv
// proc_dispatch_unit_pkg: opcodes and queue-entry layout shared by the dispatch unit
package proc_dispatch_unit_pkg;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_MUL,
        OP_AND,
        OP_OR,
        OP_XOR,
        OP_LOAD,
        OP_STORE
    } opcode_e;

    localparam int ENTRY_DATA_W = 8;
    localparam int ENTRY_ADDR_W = 12;

    // Entry layout at default widths; the top packs the same field order for any width
    typedef struct packed {
        opcode_e                 op;
        logic [ENTRY_DATA_W-1:0] a;
        logic [ENTRY_DATA_W-1:0] b;
        logic [ENTRY_ADDR_W-1:0] addr;
        logic [ENTRY_DATA_W-1:0] wdata;
    } q_entry_t;

    function automatic logic is_mem(input opcode_e op);
        return op == OP_LOAD || op == OP_STORE;
    endfunction

endpackage

// File: rtl/proc_dispatch_unit_op_fifo.sv
// op_fifo: synchronous FIFO with full/empty flags, power-of-two depth
module op_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, wr_d, rd_q, rd_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             do_push, do_pop;

    assign full  = cnt_q == (AW+1)'(DEPTH);
    assign empty = cnt_q == '0;
    assign rdata = mem_q[rd_q];

    // Blocked requests are dropped here; pointers wrap naturally at a power-of-two depth
    always_comb begin
        do_push = push && !full;
        do_pop  = pop && !empty;
        wr_d    = do_push ? wr_q + 1'b1 : wr_q;
        rd_d    = do_pop ? rd_q + 1'b1 : rd_q;
        cnt_d   = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    // Storage array, no reset needed since empty masks stale entries
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= wdata;
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/proc_dispatch_unit.sv
// proc_dispatch_unit: queued single-issue dispatcher with internal ALU and retrying cache port
module proc_dispatch_unit
    import proc_dispatch_unit_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 12,
    parameter int QDEPTH    = 4,
    parameter int MUL_LAT   = 2,
    parameter int MAX_RETRY = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                op_valid,
    output logic                op_ready,
    input  opcode_e             op_sel,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    output logic                mem_valid,
    output logic                mem_rw,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_hit,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic [2*DATA_W-1:0] result,
    output logic                result_valid,
    output opcode_e             result_op,
    output logic                result_err,
    output logic [15:0]         miss_cnt,
    output logic                busy
);
    localparam int QW    = $bits(opcode_e) + 3 * DATA_W + ADDR_W;
    localparam int RES_W = 2 * DATA_W;
    localparam int CW    = $clog2(MUL_LAT + 1);
    localparam int RW    = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM_REQ, S_RETRY} state_e;

    state_e              state_q, state_d;
    opcode_e             op_q, op_d, result_op_q, result_op_d, h_op;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, wdata_q, wdata_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CW-1:0]       cyc_q, cyc_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [RES_W-1:0]    result_q, result_d, alu_res;
    logic                result_valid_q, result_valid_d, result_err_q, result_err_d;
    logic [15:0]         miss_cnt_q, miss_cnt_d;
    logic [DATA_W:0]     sum_w, diff_w;
    logic [QW-1:0]       q_wdata, q_rdata;
    logic                q_full, q_empty, q_pop;
    logic [2:0]          h_op_bits;
    logic [DATA_W-1:0]   h_a, h_b, h_wdata;
    logic [ADDR_W-1:0]   h_addr;

    assign q_wdata = {op_sel, a, b, addr, wdata};
    assign {h_op_bits, h_a, h_b, h_addr, h_wdata} = q_rdata;
    assign h_op = opcode_e'(h_op_bits);

    op_fifo #(.WIDTH(QW), .DEPTH(QDEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (op_valid),
        .pop   (q_pop),
        .wdata (q_wdata),
        .rdata (q_rdata),
        .full  (q_full),
        .empty (q_empty)
    );

    assign op_ready     = !q_full;
    assign mem_valid    = state_q == S_MEM_REQ;
    assign mem_rw       = op_q == OP_LOAD;
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign result_op    = result_op_q;
    assign result_err   = result_err_q;
    assign miss_cnt     = miss_cnt_q;
    assign busy         = state_q != S_IDLE || !q_empty;

    // Unsigned ALU; the extra top bit of sum/diff carries carry-out or borrow
    always_comb begin
        sum_w  = {1'b0, a_q} + {1'b0, b_q};
        diff_w = {1'b0, a_q} - {1'b0, b_q};
        case (op_q)
            OP_ADD:  alu_res = RES_W'(sum_w);
            OP_SUB:  alu_res = RES_W'(diff_w);
            OP_MUL:  alu_res = RES_W'(a_q) * RES_W'(b_q);
            OP_AND:  alu_res = RES_W'(a_q & b_q);
            OP_OR:   alu_res = RES_W'(a_q | b_q);
            OP_XOR:  alu_res = RES_W'(a_q ^ b_q);
            default: alu_res = '0;
        endcase
    end

    // Dispatch FSM: pop in IDLE, execute or run the cache handshake, then complete
    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        a_d            = a_q;
        b_d            = b_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        cyc_d          = cyc_q;
        retry_d        = retry_q;
        result_d       = result_q;
        result_valid_d = 1'b0;
        result_op_d    = result_op_q;
        result_err_d   = result_err_q;
        miss_cnt_d     = miss_cnt_q;
        q_pop          = 1'b0;
        case (state_q)
            S_IDLE: if (!q_empty) begin
                q_pop   = 1'b1;
                op_d    = h_op;
                a_d     = h_a;
                b_d     = h_b;
                addr_d  = h_addr;
                wdata_d = h_wdata;
                cyc_d   = '0;
                retry_d = '0;
                state_d = is_mem(h_op) ? S_MEM_REQ : S_EXEC;
            end
            S_EXEC: if (op_q != OP_MUL || cyc_q == CW'(MUL_LAT - 1)) begin
                result_d       = alu_res;
                result_valid_d = 1'b1;
                result_op_d    = op_q;
                result_err_d   = 1'b0;
                state_d        = S_IDLE;
            end else begin
                cyc_d = cyc_q + 1'b1;
            end
            S_MEM_REQ: if (mem_gnt && mem_hit) begin
                result_d       = op_q == OP_LOAD ? RES_W'(mem_rdata) : RES_W'(wdata_q);
                result_valid_d = 1'b1;
                result_op_d    = op_q;
                result_err_d   = 1'b0;
                state_d        = S_IDLE;
            end else if (mem_gnt) begin
                miss_cnt_d = miss_cnt_q == 16'hFFFF ? miss_cnt_q : miss_cnt_q + 16'd1;
                retry_d    = retry_q + 1'b1;
                state_d    = S_RETRY;
            end
            S_RETRY: if (retry_q == RW'(MAX_RETRY)) begin
                result_d       = '0;
                result_valid_d = 1'b1;
                result_op_d    = op_q;
                result_err_d   = 1'b1;
                state_d        = S_IDLE;
            end else begin
                state_d = S_MEM_REQ;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            op_q           <= OP_ADD;
            a_q            <= '0;
            b_q            <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            cyc_q          <= '0;
            retry_q        <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
            result_op_q    <= OP_ADD;
            result_err_q   <= 1'b0;
            miss_cnt_q     <= '0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            a_q            <= a_d;
            b_q            <= b_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            cyc_q          <= cyc_d;
            retry_q        <= retry_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            result_op_q    <= result_op_d;
            result_err_q   <= result_err_d;
            miss_cnt_q     <= miss_cnt_d;
        end
    end

endmodule
